sram_read_arbiter: RTL and testbench

// - Two-master to one-slave AXI-lite read arbiter that shares the SRAM read port between IFU (m0) and LSU (m1).
// - Sits between the fetch/load units and the SRAM model, which has a 5-cycle read-data latency.
// - Allows one outstanding transaction at a time. Registers the address, sequences AR then R, and routes R back to the granted master only.

---
 rtl/sram_read_arbiter.sv | 119 +++++++++++
 tb/tb_sram_read_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arbiter.sv
// Two-master AXI-lite read arbiter sharing one SRAM read port between IFU (m0) and LSU (m1).
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority (m1 over m0).
module sram_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic [1:0]        grant_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              last_q, last_nxt;
  logic              win;  // 1 selects m1

`ifdef SRAM_ARB_RR_EN
  // On a tie the master that did not finish last wins.
  always_comb win = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
`else
  always_comb win = m1_arvalid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 2'b00;
      addr_q <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      addr_q <= addr_nxt;
      last_q <= last_nxt;
    end
  end

  assign s_araddr = addr_q;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    addr_nxt   = addr_q;
    last_nxt   = last_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    case (state)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          m0_arready = ~win;
          m1_arready = win;
          addr_nxt   = win ? m1_araddr : m0_araddr;
          grant_nxt  = win ? 2'b10 : 2'b01;
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) state_nxt = DATA;
      end
      DATA: begin
        // Read data is a combinational pass-through to the owner only.
        if (grant[1]) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && s_rready) begin
          last_nxt  = grant[1];
          grant_nxt = 2'b00;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter with a 5-cycle-latency SRAM model.
module tb_sram_read_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
  logic          m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic          m0_arready, m1_arready;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic          m0_rready = 1'b1, m1_rready = 1'b1;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid, s_arready, s_rready;
  logic          s_rvalid = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = 2'b00;
  logic [1:0]    grant;
  logic          ar_en = 1'b1;

  int total = 0;
  int bad = 0;

  sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant(grant)
  );

  always #5 clk = ~clk;
  assign s_arready = ar_en;

  // SRAM model: data = {addr[15:0], 16'h0413}, valid 5 cycles after AR handshake.
  int          cnt;
  logic        busy;
  logic [AW-1:0] raddr;
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0; busy <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; raddr <= '0;
    end else if (s_arvalid && s_arready) begin
      cnt <= 5; busy <= 1'b1; raddr <= s_araddr;
    end else if (s_rvalid) begin
      if (s_rready) begin s_rvalid <= 1'b0; busy <= 1'b0; s_rdata <= '0; end
    end else if (busy) begin
      if (cnt == 1) begin s_rvalid <= 1'b1; s_rdata <= {raddr[15:0], 16'h0413}; end
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges until master m sees rvalid.
  task automatic wait_rv(input bit m, input string tag);
    int n = 0;
    while (!(m ? m1_rvalid : m0_rvalid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rv_timeout"}, n < 40, 1);
  endtask

  // Single-master request: handshake in IDLE, then checks grant/address in ADDR.
  task automatic req1(input bit m, input logic [AW-1:0] a, input string tag);
    if (m) begin m1_arvalid = 1'b1; m1_araddr = a; end
    else   begin m0_arvalid = 1'b1; m0_araddr = a; end
    #1;
    chk({tag, "_arready"}, m ? m1_arready : m0_arready, 1);
    @(negedge clk);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    chk({tag, "_grant"}, grant, m ? 2'b10 : 2'b01);
    chk({tag, "_saddr"}, s_araddr, a);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_sarvalid", s_arvalid, 0);
    chk("rst_saddr", s_araddr, 0);
    chk("rst_srready", s_rready, 0);
    chk("rst_rvalids", {m0_rvalid, m1_rvalid, m0_arready, m1_arready}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;

    // Single IFU read
    @(negedge clk);
    req1(0, 32'h8000_0000, "ifu");
    chk("ifu_sarvalid", s_arvalid, 1);
    wait_rv(0, "ifu");
    chk("ifu_rdata", m0_rdata, 32'h0000_0413);
    chk("ifu_m1_rvalid", m1_rvalid, 0);
    chk("ifu_m1_rdata", m1_rdata, 0);
    @(negedge clk);
    chk("ifu_grant_idle", grant, 2'b00);

    // Tie with last_q=0: both builds pick m1
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0004;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0100;
    #1;
    chk("tie_arready", {m1_arready, m0_arready}, 2'b10);
    @(negedge clk);
    m1_arvalid = 1'b0;
    chk("tie_grant1", grant, 2'b10);
    chk("tie_saddr1", s_araddr, 32'h8000_0100);
    chk("tie_m0_wait", m0_arready, 0);
    wait_rv(1, "tie1");
    chk("tie_rdata1", m1_rdata, 32'h0100_0413);
    chk("tie_m0_rvalid", m0_rvalid, 0);
    @(negedge clk);
    chk("tie_idle_gap", {grant, m0_arready}, 3'b001);
    @(negedge clk);
    m0_arvalid = 1'b0;
    chk("tie_grant2", grant, 2'b01);
    chk("tie_saddr2", s_araddr, 32'h8000_0004);
    wait_rv(0, "tie2");
    chk("tie_rdata2", m0_rdata, 32'h0004_0413);
    @(negedge clk);

    // AR backpressure + address change after handshake
    ar_en = 1'b0;
    req1(0, 32'h8000_0008, "bp");
    m0_araddr = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_sarvalid", s_arvalid, 1);
      chk("bp_saddr", s_araddr, 32'h8000_0008);
      @(negedge clk);
    end
    ar_en = 1'b1;
    wait_rv(0, "bp");
    chk("bp_rdata", m0_rdata, 32'h0008_0413);
    @(negedge clk);

    // R backpressure on m1 (leaves last_q=1)
    m1_rready = 1'b0;
    req1(1, 32'h8000_0010, "rbp");
    begin
      int n = 0;
      while (!s_rvalid && n < 40) begin @(negedge clk); n++; end
      chk("rbp_srv_timeout", n < 40, 1);
    end
    for (int i = 0; i < 2; i++) begin
      chk("rbp_srready", s_rready, 0);
      chk("rbp_hold", {grant, m1_rvalid}, 3'b101);
      @(negedge clk);
    end
    m1_rready = 1'b1;
    #1;
    chk("rbp_srready_up", s_rready, 1);
    chk("rbp_rdata", m1_rdata, 32'h0010_0413);
    @(negedge clk);
    chk("rbp_grant_idle", grant, 2'b00);

    // Tie with last_q=1, twice
    for (int k = 0; k < 2; k++) begin
      logic [1:0] exp_g;
`ifdef SRAM_ARB_RR_EN
      exp_g = (k == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0020;
      m1_arvalid = 1'b1; m1_araddr = 32'h8000_0030;
      @(negedge clk);
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      chk("rr_grant", grant, exp_g);
      wait_rv(exp_g[1], "rr");
      chk("rr_rdata", exp_g[1] ? m1_rdata : m0_rdata,
          exp_g[1] ? 32'h0030_0413 : 32'h0020_0413);
      @(negedge clk);
    end

    // Reset while in DATA
    req1(0, 32'h8000_0040, "rdata");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rd_grant", grant, 2'b00);
    chk("rd_valids", {s_arvalid, s_rready, m0_rvalid, m1_rvalid}, 0);
    req1(0, 32'h8000_0044, "rd_new");
    wait_rv(0, "rd_new");
    chk("rd_new_rdata", m0_rdata, 32'h0044_0413);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
